nios_system_pio_in: RTL and testbench



---
 rtl/nios_pio_pkg.sv | 18 +
 rtl/nios_pio_edge_detect.sv | 70 +++++++
 rtl/nios_system_pio_in.sv | 80 ++++++++
 tb/tb_nios_system_pio_in.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/nios_pio_pkg.sv
// Shared constants for the Nios II input PIO: register offsets, edge-type and IRQ-mode encodings.
package nios_pio_pkg;

  typedef enum logic [1:0] {
    PIO_DATA_OFS    = 2'd0,
    PIO_RSVD_OFS    = 2'd1,
    PIO_MASK_OFS    = 2'd2,
    PIO_EDGECAP_OFS = 2'd3
  } pio_reg_e;

  localparam int PIO_EDGE_RISE = 0;
  localparam int PIO_EDGE_FALL = 1;
  localparam int PIO_EDGE_ANY  = 2;

  localparam int PIO_IRQ_LEVEL = 0;
  localparam int PIO_IRQ_EDGE  = 1;

endpackage

// File: rtl/nios_pio_edge_detect.sv
// Input conditioning for the PIO: optional 2-flop synchroniser (NIOS_PIO_IN_SYNC_EN),
// previous-sample register, post-reset arm gating and per-bit edge selection.
module nios_pio_edge_detect
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = PIO_EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] edge_pulse
);

`ifdef NIOS_PIO_IN_SYNC_EN
  localparam logic [1:0] ARM_CNT = 2'd2;

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // stage p0/p1: metastability filter on the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;
`else
  localparam logic [1:0] ARM_CNT = 2'd1;

  assign s = in_port;
`endif

  logic [WIDTH-1:0] prev_p2;
  logic [1:0]       arm_cnt;
  logic             armed;
  logic [WIDTH-1:0] raw_edge;

  // stage p2: previous sample; armed only once prev_p2 holds a real post-reset sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_p2 <= '0;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else begin
      prev_p2 <= s;
      if (arm_cnt != ARM_CNT) begin
        arm_cnt <= arm_cnt + 2'd1;
      end
      armed <= (arm_cnt == ARM_CNT);
    end
  end

  always_comb begin
    case (EDGE_TYPE)
      PIO_EDGE_FALL: raw_edge = ~s & prev_p2;
      PIO_EDGE_ANY:  raw_edge = s ^ prev_p2;
      default:       raw_edge = s & ~prev_p2;
    endcase
  end

  assign edge_pulse = armed ? raw_edge : '0;

endmodule

// File: rtl/nios_system_pio_in.sv
// Avalon-MM input PIO slave: DATA / IRQMASK / EDGECAP (W1C) registers and maskable irq.
// Build option NIOS_PIO_IN_SYNC_EN adds a 2-flop input synchroniser inside nios_pio_edge_detect.
module nios_system_pio_in
  import nios_pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_TYPE = PIO_EDGE_RISE,
  parameter int IRQ_MODE  = PIO_IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] wr_bits;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irq_src;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wr_hi;

  nios_pio_edge_detect #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_TYPE)
  ) u_edge (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .s          (s),
    .edge_pulse (edge_pulse)
  );

  assign wr_en        = chipselect & ~write_n;
  assign wr_bits      = writedata[WIDTH-1:0];
  assign unused_wr_hi = ^writedata;
  assign cap_clr      = (wr_en && address == PIO_EDGECAP_OFS) ? wr_bits : '0;

  // register stage: a fresh edge is OR'd in after the clear so it is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      edge_cap <= '0;
      data_q   <= '0;
      readdata <= '0;
    end else begin
      if (wr_en && address == PIO_MASK_OFS) begin
        irq_mask <= wr_bits;
      end
      edge_cap <= (edge_cap & ~cap_clr) | edge_pulse;
      data_q   <= s;
      readdata <= rd_next;
    end
  end

  always_comb begin
    rd_next = '0;
    case (pio_reg_e'(address))
      PIO_DATA_OFS:    rd_next[WIDTH-1:0] = s;
      PIO_MASK_OFS:    rd_next[WIDTH-1:0] = irq_mask;
      PIO_EDGECAP_OFS: rd_next[WIDTH-1:0] = edge_cap;
      default:         rd_next = '0;
    endcase
  end

  // level mode uses the registered sample so irq never sees in_port combinationally
  assign irq_src = (IRQ_MODE == PIO_IRQ_LEVEL) ? data_q : edge_cap;
  assign irq     = |(irq_src & irq_mask);

endmodule

// File: tb/tb_nios_system_pio_in.sv
// Directed bench for nios_system_pio_in: rising/edge-irq, any-edge, and 32-bit level-irq instances.
module tb_nios_system_pio_in;

`ifdef NIOS_PIO_IN_SYNC_EN
  localparam int CAP = 3;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_r = 8'hFF;
  logic [7:0]  in_a = 8'h20;
  logic [31:0] in_l = 32'd0;
  logic [31:0] rd_r, rd_a, rd_l;
  logic        irq_r, irq_a, irq_l;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios_system_pio_in #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_MODE(1)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_r), .readdata(rd_r), .irq(irq_r));

  nios_system_pio_in #(.WIDTH(8), .EDGE_TYPE(2), .IRQ_MODE(1)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

  nios_system_pio_in #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_MODE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_l), .readdata(rd_l), .irq(irq_l));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("reset_readdata", rd_r, 32'h0);
    check("reset_irq", 32'(irq_r), 32'h0);
    tick(3);
    reset_n = 1'b1;
    tick(4);

    // pins high through reset: no spurious capture
    rd(2'd3);
    check("arm_rise_cap", rd_r, 32'h0);
    check("arm_any_cap", rd_a, 32'h0);
    check("arm_irq", 32'(irq_r), 32'h0);
    rd(2'd0);
    check("arm_data", rd_r, 32'h0000_00FF);

    // rising edge on bit 0 with mask 0x01
    in_r = 8'hFE;
    tick(4);
    wr(2'd2, 32'h01);
    rd(2'd3);
    check("fall_ignored", rd_r, 32'h0);
    in_r = 8'hFF;
    tick(CAP - 1);
    check("rise_irq_early", 32'(irq_r), 32'h0);
    tick(1);
    check("rise_irq", 32'(irq_r), 32'h1);
    rd(2'd3);
    check("rise_cap", rd_r, 32'h01);
    wr(2'd3, 32'h01);
    check("w1c_irq", 32'(irq_r), 32'h0);
    rd(2'd3);
    check("w1c_cap", rd_r, 32'h0);

    // edge on bit 3 lands on the same clock as its W1C
    in_r = 8'hF7;
    tick(4);
    in_r = 8'hFF;
    tick(CAP - 1);
    wr(2'd3, 32'h08);
    rd(2'd3);
    check("edge_beats_w1c", rd_r, 32'h08);
    wr(2'd3, 32'h08);
    rd(2'd3);
    check("w1c_after", rd_r, 32'h0);

    // any-edge instance, bit 5 toggles 1->0->1 with mask 0
    wr(2'd2, 32'h0);
    wr(2'd3, 32'hFFFF_FFFF);
    in_a = 8'h00;
    tick(4);
    in_a = 8'h20;
    tick(4);
    check("any_irq_masked", 32'(irq_a), 32'h0);
    rd(2'd3);
    check("any_cap", rd_a, 32'h20);
    wr(2'd2, 32'h20);
    check("any_irq_unmask", 32'(irq_a), 32'h1);
    wr(2'd3, 32'h20);
    check("any_irq_w1c", 32'(irq_a), 32'h0);
    in_a = 8'h00;
    tick(4);
    check("any_irq_fall", 32'(irq_a), 32'h1);
    wr(2'd2, 32'h0);
    check("any_irq_maskoff", 32'(irq_a), 32'h0);
    rd(2'd3);
    check("any_cap_kept", rd_a, 32'h20);

    // level mode on the 32-bit instance
    wr(2'd2, 32'h80);
    in_l = 32'h80;
    tick(CAP - 1);
    check("lvl_irq_early", 32'(irq_l), 32'h0);
    tick(1);
    check("lvl_irq", 32'(irq_l), 32'h1);
    in_l = 32'h0;
    tick(CAP);
    check("lvl_irq_drop", 32'(irq_l), 32'h0);
    rd(2'd1);
    check("rsvd_lvl", rd_l, 32'h0);
    check("rsvd_rise", rd_r, 32'h0);
    rd(2'd2);
    check("mask_rd_lvl", rd_l, 32'h80);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2);
    check("mask_hi_zero", rd_r, 32'h0000_00FF);
    check("mask_rd_32", rd_l, 32'hFFFF_FFFF);

    // full-width data, then reset in the middle of operation
    wr(2'd3, 32'hFFFF_FFFF);
    in_l = 32'hDEAD_BEEF;
    tick(4);
    rd(2'd0);
    check("data32", rd_l, 32'hDEAD_BEEF);
    rd(2'd3);
    check("cap32", rd_l, 32'hDEAD_BEEF);
    check("lvl_irq32", 32'(irq_l), 32'h1);
    reset_n = 1'b0;
    #1;
    check("midrst_readdata", rd_l, 32'h0);
    check("midrst_irq", 32'(irq_l), 32'h0);
    tick(1);
    reset_n = 1'b1;
    rd(2'd3);
    check("midrst_cap", rd_l, 32'h0);
    tick(3);
    rd(2'd3);
    check("rearm_rise_cap", rd_r, 32'h0);
    check("rearm_lvl_irq", 32'(irq_l), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
